// File: rtl/recompose4.sv
// Serial recomposition of a dividend from quotient, divisor and remainder:
// a = q*b + r, built by shift-and-add over the four quotient bits.
module recompose4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] q,
    input  logic [3:0] b,
    input  logic [3:0] r,
    output logic [7:0] a,
    output logic       busy,
    output logic       done,
    output logic       rem_ok,
    output logic       fits4
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] q_lat_q, q_lat_d;
    logic [3:0] b_lat_q, b_lat_d;
    logic [3:0] r_lat_q, r_lat_d;
    logic [7:0] a_q, a_d;
    logic       rem_ok_q, rem_ok_d;
    logic       fits4_q, fits4_d;
    logic [7:0] acc_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= 8'd0;
            cnt_q    <= 2'd0;
            q_lat_q  <= 4'd0;
            b_lat_q  <= 4'd0;
            r_lat_q  <= 4'd0;
            a_q      <= 8'd0;
            rem_ok_q <= 1'b0;
            fits4_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            q_lat_q  <= q_lat_d;
            b_lat_q  <= b_lat_d;
            r_lat_q  <= r_lat_d;
            a_q      <= a_d;
            rem_ok_q <= rem_ok_d;
            fits4_q  <= fits4_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == 2'd3) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Partial product for the current quotient bit; peaks at 15<<3, so 8 bits never overflow.
    always_comb begin
        acc_step = acc_q + (q_lat_q[cnt_q] ? ({4'b0000, b_lat_q} << cnt_q) : 8'd0);
    end

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        q_lat_d  = q_lat_q;
        b_lat_d  = b_lat_q;
        r_lat_d  = r_lat_q;
        a_d      = a_q;
        rem_ok_d = rem_ok_q;
        fits4_d  = fits4_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_lat_d = q;
                    b_lat_d = b;
                    r_lat_d = r;
                    acc_d   = {4'b0000, r};
                    cnt_d   = 2'd0;
                end
            end
            S_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    a_d      = acc_step;
                    rem_ok_d = (r_lat_q < b_lat_q);
                    fits4_d  = (acc_step <= 8'd15);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    assign a      = a_q;
    assign rem_ok = rem_ok_q;
    assign fits4  = fits4_q;

endmodule

// File: tb/tb_recompose4.sv
// Randomized and directed bench for recompose4 against a transaction-level model.
module tb_recompose4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] q, b, r;
    logic [7:0] a;
    logic       busy, done, rem_ok, fits4;

    int n_chk  = 0;
    int n_pass = 0;

    int   last_a;
    logic last_rem_ok, last_fits4;

    recompose4 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .q      (q),
        .b      (b),
        .r      (r),
        .a      (a),
        .busy   (busy),
        .done   (done),
        .rem_ok (rem_ok),
        .fits4  (fits4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; optionally scrambles inputs and re-pulses start mid-flight.
    task automatic do_op(input logic [3:0] qi, input logic [3:0] bi, input logic [3:0] ri,
                         input bit disturb, input string tag);
        int   exp_a;
        logic exp_rok, exp_f4;
        exp_a   = int'(qi) * int'(bi) + int'(ri);
        exp_rok = (ri < bi);
        exp_f4  = (exp_a <= 15);
        q = qi; b = bi; r = ri; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check({tag, " busy run"}, busy, 1);
            check({tag, " done run"}, done, 0);
            check({tag, " a hold"}, a, last_a);
            if (disturb) begin
                q = 4'($urandom); b = 4'($urandom); r = 4'($urandom); start = 1'b1;
            end
            step();
        end
        check({tag, " done"}, done, 1);
        check({tag, " busy done"}, busy, 0);
        check({tag, " a"}, a, exp_a);
        check({tag, " rem_ok"}, rem_ok, exp_rok);
        check({tag, " fits4"}, fits4, exp_f4);
        start = 1'b0;
        step();
        check({tag, " done fall"}, done, 0);
        check({tag, " idle busy"}, busy, 0);
        check({tag, " a kept"}, a, exp_a);
        last_a = exp_a; last_rem_ok = exp_rok; last_fits4 = exp_f4;
    endtask

    initial begin
        int done_cnt;
        int first_done, second_done;
        rst = 1'b1; start = 1'b0; q = 4'd0; b = 4'd0; r = 4'd0;
        last_a = 0; last_rem_ok = 1'b0; last_fits4 = 1'b0;
        step(); step();
        check("rst a", a, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst rem_ok", rem_ok, 0);
        check("rst fits4", fits4, 0);
        rst = 1'b0;
        step();
        check("idle no start", busy, 0);

        do_op(4'd4, 4'd2, 4'd1, 1'b0, "s030");
        do_op(4'd2, 4'd7, 4'd1, 1'b0, "s031a");
        do_op(4'd1, 4'd5, 4'd3, 1'b0, "s031b");
        do_op(4'd15, 4'd15, 4'd15, 1'b0, "s032");
        do_op(4'd5, 4'd0, 4'd3, 1'b0, "s033");
        do_op(4'd6, 4'd9, 4'd2, 1'b1, "s034");
        step(); step();
        check("s034 single done", done, 0);

        // Abort on the second RUN cycle.
        q = 4'd7; b = 4'd3; r = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("s035 busy pre", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("s035 busy", busy, 0);
        check("s035 a", a, 0);
        check("s035 rem_ok", rem_ok, 0);
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) done_cnt++;
            step();
        end
        check("s035 no done", done_cnt, 0);
        last_a = 0;
        do_op(4'd3, 4'd3, 4'd0, 1'b0, "s035b");

        // Start applied while rst is high, then released.
        q = 4'd2; b = 4'd3; r = 4'd2; start = 1'b1; rst = 1'b1;
        step();
        check("r029 held", busy, 0);
        rst = 1'b0;
        step();
        check("r029 run", busy, 1);
        start = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 8 && done_cnt == 0; k++) begin
            if (done) done_cnt++;
            else step();
        end
        check("r029 done seen", done_cnt, 1);
        check("r029 a", a, 8);
        step();
        last_a = 8;

        // Start held high: done every 6 cycles.
        q = 4'd3; b = 4'd4; r = 4'd1; start = 1'b1;
        first_done = -1; second_done = -1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (done) begin
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
            end
        end
        start = 1'b0;
        check("r026 first", first_done, 5);
        check("r026 period", second_done - first_done, 6);
        check("r026 a", a, 13);
        for (int k = 0; k < 8; k++) step();
        last_a = 13;

        for (int n = 0; n < 24; n++) begin
            do_op(4'($urandom), 4'($urandom), 4'($urandom), bit'($urandom_range(0, 1)), "rand");
            if ($urandom_range(0, 1) == 1) begin
                step();
                check("rand idle a", a, last_a);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/recompose4.md
RECOMPOSE4 -- requirements
Module: recompose4

Interface
REQ-001 SHALL have no parameters; all datapath widths are fixed (4-bit operands, 8-bit result).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin a recomposition; sampled on rising clk.
REQ-005 SHALL have port: q  input  4  quotient operand, unsigned.
REQ-006 SHALL have port: b  input  4  divisor operand, unsigned.
REQ-007 SHALL have port: r  input  4  remainder operand, unsigned.
REQ-008 SHALL have port: a  output  8  registered result a = q*b + r, unsigned.
REQ-009 SHALL have port: busy  output  1  high while a computation is in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse marking a valid result.
REQ-011 SHALL have port: rem_ok  output  1  registered flag, r < b (valid remainder; 0 when b=0).
REQ-012 SHALL have port: fits4  output  1  registered flag, a <= 15 (result representable as a 4-bit dividend).

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at an edge SHALL latch q, b and r, load the accumulator with zero-extended r, clear the bit counter to 0, and enter RUN.
REQ-015 IDLE: start=0 SHALL hold all state and outputs.
REQ-016 RUN: each edge SHALL add (b << i) to the accumulator when latched q[i]=1, where i is the bit counter (0..3), then increment i.
REQ-017 RUN SHALL last exactly 4 edges; the edge processing i=3 SHALL enter DONE.
REQ-018 On entry to DONE, a SHALL take the final accumulator value, and rem_ok and fits4 SHALL be computed from the latched operands and the final value.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-020 done SHALL be 1 only in DONE, so the edge sampling start is followed by exactly 5 edges before done falls.
REQ-021 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-022 start SHALL be ignored in RUN and DONE; q, b and r SHALL NOT be sampled outside IDLE.
REQ-023 a, rem_ok and fits4 SHALL hold their last values from DONE until the next DONE; mid-computation accumulator values SHALL NOT appear on a.
REQ-024 The accumulator SHALL be 8 bits and SHALL NOT overflow: the maximum is 15*15+15 = 240.
REQ-025 b=0 SHALL yield a=r and rem_ok=0, with no error or stall.
REQ-026 start held high continuously SHALL start a new computation on the first IDLE edge after each DONE, giving a 6-cycle period.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE and a=0, busy=0, done=0, rem_ok=0 and fits4=0, and SHALL clear the accumulator, the bit counter and the latched operands.
REQ-028 rst SHALL take priority over start and over any in-flight RUN or DONE; an aborted computation SHALL produce no done pulse.
REQ-029 On the first edge after rst deasserts with start=1, the block SHALL begin a computation normally.

Verification
REQ-030 Scenario q=4, b=2, r=1, pulse start -> busy high 4 cycles, then done for one cycle with a=9, rem_ok=1, fits4=1.
REQ-031 Scenario q=2, b=7, r=1 -> a=15, rem_ok=1, fits4=1; then q=1, b=5, r=3 -> a=8, rem_ok=1, fits4=1.
REQ-032 Scenario q=15, b=15, r=15 -> a=240, rem_ok=0, fits4=0.
REQ-033 Scenario q=5, b=0, r=3 -> a=3, rem_ok=0, fits4=1.
REQ-034 Scenario: change q, b and r and pulse start during RUN -> result reflects the original operands, and exactly one done pulse occurs.
REQ-035 Scenario: assert rst on the 2nd RUN cycle -> next cycle busy=0, a=0, and no done pulse; a following start with q=3, b=3, r=0 -> a=9.
